// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_unit
// Purpose  : Pipeline hazard controller. It produces the stall, flush and
//            forwarding controls and tracks multi-cycle mult/div occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_unit #(
    parameter int MD_LATENCY = 32,
    parameter int CW         = $clog2(MD_LATENCY + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [4:0] rs_e,
    input  logic [4:0] rt_e,
    input  logic [4:0] writereg_e,
    input  logic [4:0] writereg_m,
    input  logic [4:0] writereg_w,
    input  logic       regwrite_e,
    input  logic       regwrite_m,
    input  logic       regwrite_w,
    input  logic       memtoreg_e,
    input  logic       memtoreg_m,
    input  logic       branch_d,
    input  logic       pcsrc_d,
    input  logic       md_op_d,
    input  logic       mfhilo_d,
    input  logic       md_start_e,
    output logic       stall_f,
    output logic       stall_d,
    output logic       flush_d,
    output logic       flush_e,
    output logic [1:0] forward_a_e,
    output logic [1:0] forward_b_e,
    output logic       forward_a_d,
    output logic       forward_b_d,
    output logic       md_busy,
    output logic       md_done
);

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    md_state_t     r_state;
    md_state_t     w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_done;
    logic          w_done_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // md_done is registered, so it is set on the edge where the count reaches 1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (md_start_e) begin
                    w_state_nxt = MD_BUSY;
                    w_cnt_nxt   = CW'(MD_LATENCY);
                end
            end
            MD_BUSY: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = MD_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt  = r_cnt - CW'(1);
                    w_done_nxt = (r_cnt == CW'(2));
                end
            end
            default: begin
                w_state_nxt = MD_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign md_busy = (r_state == MD_BUSY);
    assign md_done = r_done;

    logic w_e_valid;
    logic w_m_valid;
    logic w_w_valid;
    logic w_lwstall;
    logic w_brstall;
    logic w_mdstall;
    logic w_stall;

    assign w_e_valid = regwrite_e && (writereg_e != 5'd0);
    assign w_m_valid = regwrite_m && (writereg_m != 5'd0);
    assign w_w_valid = regwrite_w && (writereg_w != 5'd0);

    assign w_lwstall = memtoreg_e && (writereg_e != 5'd0) &&
                       ((writereg_e == rs_d) || (writereg_e == rt_d));
    assign w_brstall = branch_d &&
                       ((w_e_valid && ((writereg_e == rs_d) || (writereg_e == rt_d))) ||
                        (memtoreg_m && (writereg_m != 5'd0) &&
                         ((writereg_m == rs_d) || (writereg_m == rt_d))));
    assign w_mdstall = md_busy && (mfhilo_d || md_op_d);
    assign w_stall   = w_lwstall || w_brstall || w_mdstall;

    // Every control is held inactive while reset is asserted.
    always_comb begin
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        flush_e     = 1'b0;
        flush_d     = 1'b0;
        forward_a_e = 2'b00;
        forward_b_e = 2'b00;
        forward_a_d = 1'b0;
        forward_b_d = 1'b0;
        if (!reset) begin
            stall_f = w_stall;
            stall_d = w_stall;
            flush_e = w_stall;
            flush_d = pcsrc_d && !w_stall;
            if (w_m_valid && (writereg_m == rs_e))
                forward_a_e = 2'b10;
            else if (w_w_valid && (writereg_w == rs_e))
                forward_a_e = 2'b01;
            if (w_m_valid && (writereg_m == rt_e))
                forward_b_e = 2'b10;
            else if (w_w_valid && (writereg_w == rt_e))
                forward_b_e = 2'b01;
            forward_a_d = w_m_valid && (writereg_m == rs_d);
            forward_b_d = w_m_valid && (writereg_m == rt_d);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_unit
// Purpose  : Self-checking bench for hazard_unit against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

    localparam int L = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
    logic       regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m;
    logic       branch_d, pcsrc_d, md_op_d, mfhilo_d, md_start_e;
    logic       stall_f, stall_d, flush_d, flush_e, forward_a_d, forward_b_d;
    logic [1:0] forward_a_e, forward_b_e;
    logic       md_busy, md_done;

    int compared   = 0;
    int mismatched = 0;

    hazard_unit #(.MD_LATENCY(L)) dut (
        .clk(clk), .reset(reset),
        .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
        .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
        .branch_d(branch_d), .pcsrc_d(pcsrc_d), .md_op_d(md_op_d),
        .mfhilo_d(mfhilo_d), .md_start_e(md_start_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
        .md_busy(md_busy), .md_done(md_done)
    );

    always #5 clk = ~clk;

    // Mult/div occupancy as absolute time: a start accepted at edge k keeps the
    // unit busy after edges k .. k+L-1, with the write in the last of those.
    int edges      = 0;
    int start_edge = 0;
    bit have_start = 1'b0;

    function automatic bit busy_at(input int j);
        return have_start && (j >= start_edge) && (j < start_edge + L);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            have_start <= 1'b0;
            edges      <= 0;
        end else begin
            edges <= edges + 1;
            if (md_start_e && !busy_at(edges)) begin
                have_start <= 1'b1;
                start_edge <= edges + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_all();
        bit       mb, md, lw, br, st, fad, fbd;
        bit [1:0] fae, fbe;
        mb  = busy_at(edges);
        md  = have_start && (edges == start_edge + L - 1);
        lw  = memtoreg_e && writereg_e != 0 && (writereg_e == rs_d || writereg_e == rt_d);
        br  = branch_d &&
              ((regwrite_e && writereg_e != 0 && (writereg_e == rs_d || writereg_e == rt_d)) ||
               (memtoreg_m && writereg_m != 0 && (writereg_m == rs_d || writereg_m == rt_d)));
        st  = lw || br || (mb && (mfhilo_d || md_op_d));
        fae = (regwrite_m && writereg_m != 0 && writereg_m == rs_e) ? 2'd2 :
              (regwrite_w && writereg_w != 0 && writereg_w == rs_e) ? 2'd1 : 2'd0;
        fbe = (regwrite_m && writereg_m != 0 && writereg_m == rt_e) ? 2'd2 :
              (regwrite_w && writereg_w != 0 && writereg_w == rt_e) ? 2'd1 : 2'd0;
        fad = regwrite_m && writereg_m != 0 && writereg_m == rs_d;
        fbd = regwrite_m && writereg_m != 0 && writereg_m == rt_d;
        if (reset) begin
            {mb, md, st, fad, fbd, fae, fbe} = '0;
        end
        check_eq("stall_f", 32'(stall_f), 32'(st));
        check_eq("stall_d", 32'(stall_d), 32'(st));
        check_eq("flush_e", 32'(flush_e), 32'(st));
        check_eq("flush_d", 32'(flush_d), 32'(pcsrc_d && !st && !reset));
        check_eq("forward_a_e", 32'(forward_a_e), 32'(fae));
        check_eq("forward_b_e", 32'(forward_b_e), 32'(fbe));
        check_eq("forward_a_d", 32'(forward_a_d), 32'(fad));
        check_eq("forward_b_d", 32'(forward_b_d), 32'(fbd));
        check_eq("md_busy", 32'(md_busy), 32'(mb));
        check_eq("md_done", 32'(md_done), 32'(md));
    endtask

    always @(negedge clk) check_all();

    task automatic clear_in();
        {rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w} = '0;
        {regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m} = '0;
        {branch_d, pcsrc_d, md_op_d, mfhilo_d, md_start_e} = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_in();
        repeat (2) step();
        reset = 1'b0;

        // Load-use, then the load reaches M and is forwarded.
        memtoreg_e = 1; regwrite_e = 1; writereg_e = 8; rs_d = 8;
        step();
        clear_in();
        memtoreg_m = 1; regwrite_m = 1; writereg_m = 8; rs_e = 8;
        step();

        // Forward priority on rt_e.
        clear_in();
        regwrite_m = 1; regwrite_w = 1; writereg_m = 5; writereg_w = 5; rt_e = 5;
        step();
        regwrite_m = 0;
        step();
        writereg_m = 0; writereg_w = 0; regwrite_m = 1;
        step();

        // Branch hazard: producer in E, then in M.
        clear_in();
        branch_d = 1; pcsrc_d = 1; regwrite_e = 1; writereg_e = 3; rs_d = 3;
        step();
        regwrite_e = 0; writereg_e = 0; regwrite_m = 1; writereg_m = 3;
        step();

        // Mult/div interlock with a stray start while busy.
        clear_in();
        md_start_e = 1;
        step();
        md_start_e = 0;
        step();
        mfhilo_d = 1;
        step();
        md_start_e = 1;
        step();
        md_start_e = 0; md_op_d = 1;
        repeat (4) step();

        // Reset during BUSY, then a full restart.
        clear_in();
        md_start_e = 1;
        step();
        md_start_e = 0;
        step();
        #2;
        reset = 1'b1;
        #1;
        check_all();
        step();
        reset = 1'b0;
        md_start_e = 1;
        step();
        md_start_e = 0;
        repeat (L + 2) step();

        // Randomised traffic from a small register pool to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            rs_d = 5'($urandom_range(0, 3));  rt_d = 5'($urandom_range(0, 3));
            rs_e = 5'($urandom_range(0, 3));  rt_e = 5'($urandom_range(0, 3));
            writereg_e = 5'($urandom_range(0, 3));
            writereg_m = 5'($urandom_range(0, 3));
            writereg_w = 5'($urandom_range(0, 3));
            regwrite_e = 1'($urandom);  regwrite_m = 1'($urandom);
            regwrite_w = 1'($urandom);  memtoreg_e = 1'($urandom);
            memtoreg_m = 1'($urandom);  branch_d   = 1'($urandom);
            pcsrc_d    = 1'($urandom);  md_op_d    = 1'($urandom);
            mfhilo_d   = 1'($urandom);
            md_start_e = !busy_at(edges) && ($urandom_range(0, 3) == 0);
            if (reset)
                reset = 1'b0;
            else if ($urandom_range(0, 199) == 0)
                reset = 1'b1;
            step();
        end

        reset = 1'b0;
        clear_in();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
